int_issue_queue: RTL

Integer-unit issue queue: holds dispatched integer instructions, snoops the common data bus (CDB) to wake up operands by tag match, and presents the oldest fully-ready instruction to the issue unit. It drives the `issue_rdy` request into the CDB-slot arbiter and consumes the matching grant. It is the CDB consumer and request originator for the integer path of the out-of-order core.

---
 rtl/int_issue_queue.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing age-ordered entry array with CDB operand wake-up,
// oldest-ready selection toward the issue unit, and dispatch-time CDB bypass.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         flush,
  input  logic                         disp_en,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [TAG_W-1:0]             disp_rd_tag,
  input  logic                         disp_rs1_rdy,
  input  logic                         disp_rs2_rdy,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic [DATA_W-1:0]            disp_rs1_data,
  input  logic [DATA_W-1:0]            disp_rs2_data,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         issue_granted,
  output logic                         issue_rdy,
  output logic [OP_W-1:0]              issue_op,
  output logic [TAG_W-1:0]             issue_rd_tag,
  output logic [DATA_W-1:0]            issue_rs1_data,
  output logic [DATA_W-1:0]            issue_rs2_data,
  output logic                         queue_full,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rd_tag;
    logic              rs1_rdy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_data;
    logic              rs2_rdy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_data;
  } entry_t;

  entry_t        q     [DEPTH];
  entry_t        q_nxt [DEPTH];
  entry_t        disp_entry;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] wr_idx;
  logic [CW-1:0] count_nxt;
  logic          grant;
  logic          accept;

  // Oldest fully-ready entry wins; scanning downward leaves the lowest index in sel_idx.
  always_comb begin
    issue_rdy = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy) begin
        issue_rdy = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign issue_op       = issue_rdy ? q[sel_idx].op       : '0;
  assign issue_rd_tag   = issue_rdy ? q[sel_idx].rd_tag   : '0;
  assign issue_rs1_data = issue_rdy ? q[sel_idx].rs1_data : '0;
  assign issue_rs2_data = issue_rdy ? q[sel_idx].rs2_data : '0;

  assign queue_full = (queue_count == CW'(DEPTH));
  assign grant      = issue_granted && issue_rdy;
  assign accept     = disp_en && !queue_full;
  assign wr_idx     = queue_count - CW'(grant);
  assign count_nxt  = queue_count + CW'(accept) - CW'(grant);

  always_comb begin
    disp_entry.valid    = 1'b1;
    disp_entry.op       = disp_op;
    disp_entry.rd_tag   = disp_rd_tag;
    disp_entry.rs1_tag  = disp_rs1_tag;
    disp_entry.rs2_tag  = disp_rs2_tag;
    disp_entry.rs1_rdy  = disp_rs1_rdy;
    disp_entry.rs2_rdy  = disp_rs2_rdy;
    disp_entry.rs1_data = disp_rs1_data;
    disp_entry.rs2_data = disp_rs2_data;
    if (cdb_valid && !disp_rs1_rdy && disp_rs1_tag == cdb_tag) begin
      disp_entry.rs1_rdy  = 1'b1;
      disp_entry.rs1_data = cdb_data;
    end
    if (cdb_valid && !disp_rs2_rdy && disp_rs2_tag == cdb_tag) begin
      disp_entry.rs2_rdy  = 1'b1;
      disp_entry.rs2_data = cdb_data;
    end
  end

  // Collapse first, then wake at post-shift positions, then append the dispatch.
  // NOTE: always_comb uses blocking '=' so each stage sees the previous stage's result;
  // only the always_ff below uses '<='.
  always_comb begin
    q_nxt = q;
    if (grant) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= sel_idx) q_nxt[i] = q[i+1];
      end
      q_nxt[DEPTH-1].valid = 1'b0;
    end
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_nxt[i].valid && !q_nxt[i].rs1_rdy && q_nxt[i].rs1_tag == cdb_tag) begin
          q_nxt[i].rs1_rdy  = 1'b1;
          q_nxt[i].rs1_data = cdb_data;
        end
        if (q_nxt[i].valid && !q_nxt[i].rs2_rdy && q_nxt[i].rs2_tag == cdb_tag) begin
          q_nxt[i].rs2_rdy  = 1'b1;
          q_nxt[i].rs2_data = cdb_data;
        end
      end
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) q_nxt[i] = disp_entry;
      end
    end
  end

  // NOTE: reset and flush clear only the valid bits; payload fields are don't-care
  // while invalid, and the issue outputs are gated to zero without a ready entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      queue_count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      queue_count <= count_nxt;
      q           <= q_nxt;
    end
  end

endmodule
